// File: rtl/io_port_bank.sv
// ==== io_port_bank : memory-mapped I/O port bank with synchronised inputs, sticky change flags and irq (rev 1.0) ====
`default_nettype none

module io_port_bank #(
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    ADDR_WIDTH  = 8,
  parameter int                    NUM_PORTS   = 16,
  parameter logic [ADDR_WIDTH-1:0] OUT_BASE    = 8'hC0,
  parameter logic [ADDR_WIDTH-1:0] IN_BASE     = 8'hD0,
  parameter logic [ADDR_WIDTH-1:0] CHG_BASE    = 8'hE0,
  parameter logic [ADDR_WIDTH-1:0] IEN_BASE    = 8'hE8,
  parameter int                    SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           address,
  input  logic [DATA_WIDTH-1:0]           data_in,
  input  logic                            write,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            hit,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] port_in,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_out,
  output logic                            irq
);

  localparam int NW = (NUM_PORTS + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FW = NW * DATA_WIDTH;
  localparam int PW = NUM_PORTS * DATA_WIDTH;
  localparam logic [ADDR_WIDTH:0] C_NP = (ADDR_WIDTH+1)'(NUM_PORTS);
  localparam logic [ADDR_WIDTH:0] C_NW = (ADDR_WIDTH+1)'(NW);

  logic [PW-1:0]         port_out_q, port_out_d;
  logic [PW-1:0]         sync_q [SYNC_STAGES];
  logic [PW-1:0]         prev_q;
  logic [NUM_PORTS-1:0]  chg_q, chg_d, ien_q, ien_d, evt;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  hit_q, hit_d, irq_q;

  logic [ADDR_WIDTH-1:0] out_off, in_off, chg_off, ien_off;
  logic                  out_hit, in_hit, chg_hit, ien_hit;
  logic [PW-1:0]         sync_last;
  logic [FW-1:0]         chg_cur, ien_cur, ien_nxt, clr;

  assign out_off = address - OUT_BASE;
  assign in_off  = address - IN_BASE;
  assign chg_off = address - CHG_BASE;
  assign ien_off = address - IEN_BASE;

  // Windows are legal only if they fit in the address space, so no wrap check is needed.
  assign out_hit = (address >= OUT_BASE) && ({1'b0, out_off} < C_NP);
  assign in_hit  = (address >= IN_BASE)  && ({1'b0, in_off}  < C_NP);
  assign chg_hit = (address >= CHG_BASE) && ({1'b0, chg_off} < C_NW);
  assign ien_hit = (address >= IEN_BASE) && ({1'b0, ien_off} < C_NW);

  assign sync_last = sync_q[SYNC_STAGES-1];

  always_comb begin
    port_out_d = port_out_q;
    data_out_d = '0;
    evt        = '0;
    clr        = '0;
    chg_cur    = '0;
    ien_cur    = '0;
    chg_cur[NUM_PORTS-1:0] = chg_q;
    ien_cur[NUM_PORTS-1:0] = ien_q;
    ien_nxt    = ien_cur;
    hit_d      = out_hit | in_hit | chg_hit | ien_hit;

    for (int i = 0; i < NUM_PORTS; i++) begin
      if (out_hit && (out_off == ADDR_WIDTH'(i))) begin
        data_out_d = port_out_q[i*DATA_WIDTH +: DATA_WIDTH];
        if (write) port_out_d[i*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
      if (in_hit && (in_off == ADDR_WIDTH'(i)))
        data_out_d = sync_last[i*DATA_WIDTH +: DATA_WIDTH];
      evt[i] = (sync_last[i*DATA_WIDTH +: DATA_WIDTH] != prev_q[i*DATA_WIDTH +: DATA_WIDTH]);
    end

    for (int k = 0; k < NW; k++) begin
      if (chg_hit && (chg_off == ADDR_WIDTH'(k))) begin
        data_out_d = chg_cur[k*DATA_WIDTH +: DATA_WIDTH];
        if (write) clr[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
      if (ien_hit && (ien_off == ADDR_WIDTH'(k))) begin
        data_out_d = ien_cur[k*DATA_WIDTH +: DATA_WIDTH];
        if (write) ien_nxt[k*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
    end

    // A change event on the same edge as a W1C keeps the flag set.
    chg_d = (chg_q & ~clr[NUM_PORTS-1:0]) | evt;
    ien_d = ien_nxt[NUM_PORTS-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q <= '0;
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q     <= '0;
      chg_q      <= '0;
      ien_q      <= '0;
      data_out_q <= '0;
      hit_q      <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      port_out_q <= port_out_d;
      sync_q[0]  <= port_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q     <= sync_last;
      chg_q      <= chg_d;
      ien_q      <= ien_d;
      data_out_q <= data_out_d;
      hit_q      <= hit_d;
      irq_q      <= |(chg_q & ien_q);
    end
  end

  assign port_out = port_out_q;
  assign data_out = data_out_q;
  assign hit      = hit_q;
  assign irq      = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_io_port_bank.sv
// ==== tb_io_port_bank : directed scoreboard bench for io_port_bank (rev 1.0) ====
`default_nettype none

module tb_io_port_bank;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int NP = 16;
  localparam int PW = NP * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          write;
  logic [AW-1:0] address;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          hit;
  logic          irq;
  logic [PW-1:0] port_in;
  logic [PW-1:0] port_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          hit;
  } rd_exp_t;

  rd_exp_t       sb_q[$];
  string         tag_q[$];
  logic [PW-1:0] exp_po;

  always #5 clk = ~clk;

  io_port_bank dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .data_in  (data_in),
    .write    (write),
    .data_out (data_out),
    .hit      (hit),
    .port_in  (port_in),
    .port_out (port_out),
    .irq      (irq)
  );

  task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    address = a;
    data_in = d;
    write   = 1'b1;
    tick();
    write   = 1'b0;
  endtask

  task automatic bus_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] ed, input logic eh);
    rd_exp_t e;
    string   t;
    address = a;
    write   = 1'b0;
    sb_q.push_back('{data: ed, hit: eh});
    tag_q.push_back(tag);
    tick();
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    check({t, "_data"}, PW'(data_out), PW'(e.data));
    check({t, "_hit"},  PW'(hit),      PW'(e.hit));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b0;
    write   = 1'b0;
    address = '0;
    data_in = '0;
    port_in = '0;
    exp_po  = '0;
    #12;
    check("rst_port_out", port_out, '0);
    check("rst_data_out", PW'(data_out), '0);
    check("rst_hit", PW'(hit), '0);
    check("rst_irq", PW'(irq), '0);
    tick();
    reset = 1'b1;
    tick();

    // Output register write, readback, read-during-write
    bus_write(8'hC3, 8'hA5);
    exp_po[3*DW +: DW] = 8'hA5;
    check("out_write", port_out, exp_po);
    bus_read("out_rd", 8'hC3, 8'hA5, 1'b1);
    bus_write(8'hC3, 8'h5A);
    check("rdw_old", PW'(data_out), PW'(8'hA5));
    exp_po[3*DW +: DW] = 8'h5A;
    bus_read("raw_new", 8'hC3, 8'h5A, 1'b1);

    // Input synchroniser latency and change flag
    port_in[7*DW +: DW] = 8'h3C;
    bus_read("in_lat1", 8'hD7, 8'h00, 1'b1);
    bus_read("in_lat2", 8'hD7, 8'h00, 1'b1);
    bus_read("in_lat3", 8'hD7, 8'h3C, 1'b1);
    bus_read("chg_w0", 8'hE0, 8'h80, 1'b1);
    bus_write(8'hD7, 8'h3C);
    check("in_wr_ignored", port_out, exp_po);
    bus_read("chg_w0_keep", 8'hE0, 8'h80, 1'b1);

    // Interrupt enable and W1C
    bus_write(8'hE9, 8'h01);
    bus_read("ien_w1", 8'hE9, 8'h01, 1'b1);
    port_in[8*DW +: DW] = 8'h11;
    tick();
    tick();
    tick();
    check("irq_not_yet", PW'(irq), '0);
    tick();
    check("irq_set", PW'(irq), PW'(1'b1));
    bus_read("chg_w1", 8'hE1, 8'h01, 1'b1);
    bus_write(8'hE1, 8'h01);
    check("irq_hold", PW'(irq), PW'(1'b1));
    tick();
    check("irq_clr", PW'(irq), '0);
    bus_read("chg_w1_clr", 8'hE1, 8'h00, 1'b1);

    // Event and W1C on the same edge: set wins; bit 7 clears
    port_in[2*DW +: DW] = 8'h01;
    tick();
    tick();
    bus_write(8'hE0, 8'h84);
    bus_read("set_wins", 8'hE0, 8'h04, 1'b1);
    bus_write(8'hE0, 8'h04);
    bus_read("chg_w0_clr", 8'hE0, 8'h00, 1'b1);

    // Unmapped address
    bus_read("unmapped", 8'h10, 8'h00, 1'b0);
    bus_write(8'h10, 8'hFF);
    check("unmapped_wr", port_out, exp_po);
    bus_read("ien_w0_keep", 8'hE8, 8'h00, 1'b1);
    bus_read("ien_w1_keep", 8'hE9, 8'h01, 1'b1);
    bus_read("chg_w0_keep2", 8'hE0, 8'h00, 1'b1);

    // Asynchronous reset mid-operation
    bus_write(8'hC0, 8'h55);
    exp_po[0*DW +: DW] = 8'h55;
    port_in[8*DW +: DW] = 8'h22;
    for (int n = 0; n < 4; n++) bus_read("pre_rst", 8'hC0, 8'h55, 1'b1);
    check("pre_rst_irq", PW'(irq), PW'(1'b1));
    port_in[0*DW +: DW] = 8'h01;
    #3;
    reset = 1'b0;
    #1;
    exp_po = '0;
    check("arst_port_out", port_out, exp_po);
    check("arst_data_out", PW'(data_out), '0);
    check("arst_hit", PW'(hit), '0);
    check("arst_irq", PW'(irq), '0);
    tick();
    reset = 1'b1;
    bus_read("rel_lat1", 8'hE0, 8'h00, 1'b1);
    bus_read("rel_lat2", 8'hE0, 8'h00, 1'b1);
    bus_read("rel_lat3", 8'hE0, 8'h00, 1'b1);
    bus_read("rel_chg0", 8'hE0, 8'h85, 1'b1);
    bus_read("rel_chg1", 8'hE1, 8'h01, 1'b1);
    bus_read("rel_ien1", 8'hE9, 8'h00, 1'b1);
    check("rel_irq", PW'(irq), '0);
    check("rel_port_out", port_out, exp_po);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
